// File: rtl/ctrl_spi_slave.sv
// SPI mode-3 target with qmem-mapped RX/TX byte FIFOs, status flags and a level irq.
// The SPI pins are asynchronous and are oversampled in the clk domain.
module ctrl_spi_slave_fifo #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);
  logic [W-1:0]  mem_q [0:(1<<AW)-1];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = cnt_q[AW];
  assign count   = cnt_q;
  assign rdata   = mem_q[rp_q];
  // Flush overrides any push/pop issued in the same cycle.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_comb begin
    wp_d  = wp_q + AW'(do_push);
    rp_d  = rp_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wdata;
  end
endmodule

module ctrl_spi_slave #(
  parameter int QAW     = 22,
  parameter int QDW     = 32,
  parameter int QSW     = QDW/8,
  parameter int FIFO_AW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [QAW-1:0] adr,
  input  logic           cs,
  input  logic           we,
  input  logic [QSW-1:0] sel,
  input  logic [QDW-1:0] dat_w,
  output logic [QDW-1:0] dat_r,
  output logic           ack,
  output logic           err,
  input  logic           spi_cs_n,
  input  logic           spi_clk,
  input  logic           spi_di,
  output logic           spi_do,
  output logic           spi_do_oe,
  output logic           irq
);
  logic [1:0] sclk_s_q, di_s_q, csn_s_q, warm_q;
  logic       sclk_d_q, csn_d_q, armed_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d, idle_q, idle_d, rx_byte;
  logic       first_q, first_d, ovr_q, ovr_d, und_q, und_d, irq_q, irq_d;
  logic [2:0] ctrl_q, ctrl_d;
  logic [1:0] radr_q, radr_d;
  logic       rd_q, rd_d;
  logic [7:0] rx_head, tx_head;
  logic [FIFO_AW:0] rx_cnt, tx_cnt;
  logic       rx_empty, rx_full, tx_empty, tx_full;
  logic       rx_push, tx_pop, rd_pop, load_next, tx_push, rx_flush, tx_flush;
  logic       wr_data, wr_stat, wr_ctrl, wr_idle;
  logic       sclk_rise, sclk_fall, cs_act, frame_start, cs_end;
  logic [1:0] reg_sel;
  logic       unused_ok;

  assign reg_sel  = adr[3:2];
  assign wr_data  = cs & we & (reg_sel == 2'd0);
  assign wr_stat  = cs & we & (reg_sel == 2'd1);
  assign wr_ctrl  = cs & we & (reg_sel == 2'd2);
  assign wr_idle  = cs & we & (reg_sel == 2'd3);
  assign ack      = ~(wr_data & tx_full);
  assign err      = 1'b0;
  assign tx_push  = wr_data & ~tx_full;
  assign rx_flush = wr_ctrl & dat_w[8];
  assign tx_flush = wr_ctrl & dat_w[9];
  assign rd_pop   = rd_q & (radr_q == 2'd0) & ~rx_empty;
  assign unused_ok = ^{sel, adr[QAW-1:4], adr[1:0], dat_w[QDW-1:10]};

  assign sclk_rise = sclk_s_q[1] & ~sclk_d_q;
  assign sclk_fall = ~sclk_s_q[1] & sclk_d_q;
  // armed_q blocks a CS that was already low when reset released from starting a frame.
  assign cs_act      = armed_q & ~csn_s_q[1];
  assign frame_start = cs_act & csn_d_q;
  assign cs_end      = csn_s_q[1] & ~csn_d_q;
  assign rx_byte     = {rx_shift_q[6:0], di_s_q[1]};
  assign spi_do      = cs_act ? tx_shift_q[7] : 1'b1;
  assign spi_do_oe   = cs_act;
  assign irq         = irq_q;

  ctrl_spi_slave_fifo #(.W(8), .AW(FIFO_AW)) u_rx (
    .clk(clk), .rst_n(rst_n), .flush(rx_flush), .push(rx_push), .pop(rd_pop),
    .wdata(rx_byte), .rdata(rx_head), .count(rx_cnt), .empty(rx_empty), .full(rx_full));

  ctrl_spi_slave_fifo #(.W(8), .AW(FIFO_AW)) u_tx (
    .clk(clk), .rst_n(rst_n), .flush(tx_flush), .push(tx_push), .pop(tx_pop),
    .wdata(dat_w[7:0]), .rdata(tx_head), .count(tx_cnt), .empty(tx_empty), .full(tx_full));

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    first_d    = first_q;
    ovr_d      = ovr_q & ~(wr_stat & dat_w[4]);
    und_d      = und_q & ~(wr_stat & dat_w[5]);
    rx_push    = 1'b0;
    tx_pop     = 1'b0;
    load_next  = 1'b0;
    if (frame_start) begin
      bit_cnt_d  = '0;
      rx_shift_d = '0;
      first_d    = 1'b1;
      load_next  = 1'b1;
    end else if (cs_act && sclk_rise) begin
      rx_shift_d = rx_byte;
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_push = 1'b1;
        first_d = 1'b0;
        if (rx_full) ovr_d = 1'b1;
      end
    end else if (cs_act && sclk_fall) begin
      if (bit_cnt_q != 3'd0) tx_shift_d = {tx_shift_q[6:0], 1'b1};
      else if (!first_q)     load_next  = 1'b1;
    end else if (cs_end) begin
      bit_cnt_d = '0;
    end
    if (load_next) begin
      if (tx_empty) begin
        tx_shift_d = idle_q;
        und_d      = 1'b1;
      end else begin
        tx_shift_d = tx_head;
        tx_pop     = 1'b1;
      end
    end
  end

  always_comb begin
    ctrl_d = wr_ctrl ? dat_w[2:0] : ctrl_q;
    idle_d = wr_idle ? dat_w[7:0] : idle_q;
    radr_d = cs ? reg_sel : radr_q;
    rd_d   = cs & ~we;
    irq_d  = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty) | (ctrl_q[2] & (ovr_q | und_q));
    case (radr_q)
      2'd0:    dat_r = QDW'({24'h0, rx_empty ? 8'h00 : rx_head});
      2'd1:    dat_r = QDW'({8'h0, 8'(tx_cnt), 8'(rx_cnt), 1'b0, cs_act, und_q, ovr_q,
                             tx_full, tx_empty, rx_full, ~rx_empty});
      2'd2:    dat_r = QDW'({29'h0, ctrl_q});
      default: dat_r = QDW'({24'h0, idle_q});
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s_q   <= 2'b11;
      di_s_q     <= 2'b11;
      csn_s_q    <= 2'b11;
      sclk_d_q   <= 1'b1;
      csn_d_q    <= 1'b1;
      warm_q     <= 2'b00;
      armed_q    <= 1'b0;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= 8'hFF;
      first_q    <= 1'b1;
      ovr_q      <= 1'b0;
      und_q      <= 1'b0;
      irq_q      <= 1'b0;
      ctrl_q     <= '0;
      idle_q     <= 8'hFF;
      radr_q     <= '0;
      rd_q       <= 1'b0;
    end else begin
      sclk_s_q   <= {sclk_s_q[0], spi_clk};
      di_s_q     <= {di_s_q[0], spi_di};
      csn_s_q    <= {csn_s_q[0], spi_cs_n};
      sclk_d_q   <= sclk_s_q[1];
      csn_d_q    <= csn_s_q[1];
      warm_q     <= {warm_q[0], 1'b1};
      armed_q    <= armed_q | (warm_q[1] & csn_s_q[1]);
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      first_q    <= first_d;
      ovr_q      <= ovr_d;
      und_q      <= und_d;
      irq_q      <= irq_d;
      ctrl_q     <= ctrl_d;
      idle_q     <= idle_d;
      radr_q     <= radr_d;
      rd_q       <= rd_d;
    end
  end
endmodule

// File: tb/tb_ctrl_spi_slave.sv
// Directed bench for ctrl_spi_slave: a mode-3 SPI master model plus qmem register accesses.
module tb_ctrl_spi_slave;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [21:0] adr = '0;
  logic        cs = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] dat_w = '0, dat_r;
  logic        ack, err;
  logic        spi_cs_n = 1'b1, spi_clk = 1'b1, spi_di = 1'b1;
  logic        spi_do, spi_do_oe, irq;
  int          n_chk = 0, n_fail = 0;

  localparam logic [1:0] R_DATA = 2'd0, R_STAT = 2'd1, R_CTRL = 2'd2, R_IDLE = 2'd3;

  always #5 clk = ~clk;

  ctrl_spi_slave dut (
    .clk(clk), .rst_n(rst_n), .adr(adr), .cs(cs), .we(we), .sel(sel),
    .dat_w(dat_w), .dat_r(dat_r), .ack(ack), .err(err),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_di(spi_di),
    .spi_do(spi_do), .spi_do_oe(spi_do_oe), .irq(irq));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic qwr(input logic [1:0] r, input logic [31:0] d);
    int t;
    @(negedge clk);
    cs = 1'b1; we = 1'b1; adr = {18'h0, r, 2'b00}; dat_w = d; t = 0;
    while (!ack && t < 1000) begin @(negedge clk); t++; end
    if (!ack) check("qwr_timeout", 32'(ack), 32'd1);
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic qrd(input logic [1:0] r, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; adr = {18'h0, r, 2'b00};
    @(negedge clk);
    cs = 1'b0;
    d = dat_r;
  endtask

  task automatic spi_bit(input logic bo, output logic bi);
    spi_clk = 1'b0; spi_di = bo;
    clks(4);
    bi = spi_do;
    spi_clk = 1'b1;
    clks(4);
  endtask

  task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi);
    logic b;
    for (int i = 7; i >= 0; i--) begin spi_bit(mo[i], b); mi[i] = b; end
  endtask

  task automatic spi_begin();
    @(negedge clk); spi_cs_n = 1'b0; clks(4);
  endtask

  task automatic spi_end();
    clks(2); spi_cs_n = 1'b1; clks(6);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  m;
    logic        b;
    clks(3); rst_n = 1'b1; clks(5);
    // reset state
    check("rst_dat_r", dat_r, 32'h0);
    check("rst_spi_do", 32'(spi_do), 32'd1);
    check("rst_oe", 32'(spi_do_oe), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ack_err", {30'h0, ack, err}, 32'h2);
    qrd(R_STAT, d); check("rst_status", d, 32'h0000_0004);
    qrd(R_IDLE, d); check("rst_idle", d, 32'h0000_00FF);
    qrd(R_CTRL, d); check("rst_ctrl", d, 32'h0);

    // two-byte full-duplex frame
    qwr(R_DATA, 32'hA5); qwr(R_DATA, 32'h3C);
    spi_begin(); spi_byte(8'h12, m); check("t1_miso0", 32'(m), 32'hA5);
    spi_byte(8'h34, m); check("t1_miso1", 32'(m), 32'h3C); spi_end();
    qrd(R_STAT, d); check("t1_status", d, 32'h0000_0205);
    qrd(R_DATA, d); check("t1_rx0", d, 32'h12);
    qrd(R_DATA, d); check("t1_rx1", d, 32'h34);
    qrd(R_STAT, d); check("t1_status_end", d, 32'h0000_0004);

    // underrun sends IDLE
    qwr(R_IDLE, 32'h5A); qrd(R_IDLE, d); check("t2_idle", d, 32'h5A);
    spi_begin(); spi_byte(8'h77, m); spi_end();
    check("t2_miso", 32'(m), 32'h5A);
    qrd(R_STAT, d); check("t2_status", d, 32'h0000_0125);
    qwr(R_STAT, 32'h20);
    qrd(R_STAT, d); check("t2_status_clr", d, 32'h0000_0105);
    qrd(R_DATA, d); check("t2_rx", d, 32'h77);

    // RX overrun on the 9th byte
    qwr(R_CTRL, 32'h4);
    spi_begin();
    for (int i = 1; i <= 9; i++) spi_byte(8'(i), m);
    spi_end();
    qrd(R_STAT, d); check("t3_status", d, 32'h0000_0837);
    check("t3_irq", 32'(irq), 32'd1);
    for (int i = 1; i <= 8; i++) begin qrd(R_DATA, d); check("t3_rx", d, 32'(i)); end
    qwr(R_STAT, 32'h30); clks(2);
    check("t3_irq_clr", 32'(irq), 32'd0);
    qrd(R_STAT, d); check("t3_status_end", d, 32'h0000_0004);

    // TX full stall
    qwr(R_CTRL, 32'h0);
    for (int i = 0; i < 8; i++) qwr(R_DATA, 32'h10 + 32'(i));
    qrd(R_STAT, d); check("t4_status_full", d, 32'h0008_0008);
    @(negedge clk); cs = 1'b1; we = 1'b1; adr = '0; dat_w = 32'h99;
    clks(5); check("t4_stall_ack", 32'(ack), 32'd0);
    fork
      begin
        int t; t = 0;
        while (!ack && t < 500) begin @(negedge clk); t++; end
        check("t4_release_ack", 32'(ack), 32'd1);
        @(negedge clk); cs = 1'b0; we = 1'b0;
      end
      begin
        spi_begin(); spi_byte(8'hEE, m); spi_end();
      end
    join
    check("t4_miso_first", 32'(m), 32'h10);
    qrd(R_STAT, d); check("t4_status_refill", d, 32'h0008_0109);
    spi_begin();
    for (int i = 1; i <= 8; i++) begin
      spi_byte(8'h00, m);
      check("t4_miso", 32'(m), (i == 8) ? 32'h99 : 32'h10 + 32'(i));
    end
    spi_end();
    qwr(R_CTRL, 32'h300); qwr(R_STAT, 32'h30);
    qrd(R_STAT, d); check("t4_status_flushed", d, 32'h0000_0004);

    // CS abort after 4 bits
    qwr(R_DATA, 32'hC3); qwr(R_DATA, 32'h81);
    spi_begin();
    for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
    spi_end();
    qrd(R_STAT, d); check("t5_status_abort", d, 32'h0001_0000);
    spi_begin(); spi_byte(8'h5B, m); spi_end();
    check("t5_miso", 32'(m), 32'h81);
    qrd(R_DATA, d); check("t5_rx_aligned", d, 32'h5B);
    qrd(R_STAT, d); check("t5_status_end", d, 32'h0000_0004);

    // rx_flush lands on the same clk as the 2nd byte's RX push
    spi_begin(); spi_byte(8'hAA, m);
    for (int i = 0; i < 7; i++) spi_bit(1'b1, b);
    spi_clk = 1'b0; spi_di = 1'b1; clks(4);
    spi_clk = 1'b1; clks(2);
    cs = 1'b1; we = 1'b1; adr = {18'h0, R_CTRL, 2'b00}; dat_w = 32'h100;
    @(negedge clk); cs = 1'b0; we = 1'b0;
    clks(4); spi_end();
    qrd(R_STAT, d); check("t6_status_flush", d, 32'h0000_0024);
    qwr(R_STAT, 32'h30);

    // async reset mid-frame
    qwr(R_DATA, 32'h42);
    spi_begin();
    for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
    check("t7_oe_active", 32'(spi_do_oe), 32'd1);
    @(negedge clk); rst_n = 1'b0; #1;
    check("t7_rst_do_oe", {30'h0, spi_do, spi_do_oe}, 32'h2);
    clks(3); rst_n = 1'b1; clks(10);
    check("t7_no_frame", 32'(spi_do_oe), 32'd0);
    qrd(R_STAT, d); check("t7_status", d, 32'h0000_0004);
    spi_cs_n = 1'b1; clks(6);
    qwr(R_DATA, 32'h66);
    spi_begin(); spi_byte(8'h19, m); spi_end();
    check("t7_miso", 32'(m), 32'h66);
    qrd(R_DATA, d); check("t7_rx", d, 32'h19);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
